// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - ID/EXE pipeline stage register with optional skid entry (PIPE_STAGE_SKID_EN)
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc_plus2_in,
    input  logic [DATA_W-1:0] op1_in,
    input  logic [DATA_W-1:0] op2_in,
    input  logic [DATA_W-1:0] extend_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus2_out,
    output logic [DATA_W-1:0] op1_out,
    output logic [DATA_W-1:0] op2_out,
    output logic [DATA_W-1:0] extend_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int BUNDLE_W = 5 * DATA_W + RD_W;

    // EMPTY: nothing held; BUSY: main entry valid; FULL: main and skid entries valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BUNDLE_W-1:0] in_bundle;
    logic [BUNDLE_W-1:0] m_data_q;
    logic [BUNDLE_W-1:0] m_data_d;
    logic                accept;
    logic                consume;

    assign in_bundle = {pc_in, pc_plus2_in, op1_in, op2_in, extend_in, rd_in};
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    assign {pc_out, pc_plus2_out, op1_out, op2_out, extend_out, rd_out} = m_data_q;

`ifdef PIPE_STAGE_SKID_EN

    logic [BUNDLE_W-1:0] s_data_q;
    logic [BUNDLE_W-1:0] s_data_d;
    logic                in_ready_q;

    // in_ready comes straight from a flop so out_ready never reaches the upstream handshake
    assign in_ready = in_ready_q;

    // Next-state and entry-load selection for the two-entry stage
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    m_data_d = in_bundle;
                end
            end
            ST_BUSY: begin
                if (accept && consume) begin
                    m_data_d = in_bundle;
                end else if (accept) begin
                    state_d  = ST_FULL;
                    s_data_d = in_bundle;
                end else if (consume) begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d  = ST_BUSY;
                    m_data_d = s_data_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // A kill drops everything; stored data is left untouched since it is marked invalid
        if (flush) begin
            state_d  = ST_EMPTY;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
        end
    end

    // Skid entry data and the registered ready, which is high whenever the skid entry is free
    always_ff @(posedge clk) begin
        if (reset) begin
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            s_data_q   <= s_data_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

`else

    // Single-entry stage: room exists if empty or if the held bundle leaves this cycle
    assign in_ready = (state_q == ST_EMPTY) | out_ready;

    // Next-state and main-entry load selection for the single-entry stage
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    m_data_d = in_bundle;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    m_data_d = in_bundle;
                end else if (consume) begin
                    state_d  = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // A kill drops everything; stored data is left untouched since it is marked invalid
        if (flush) begin
            state_d  = ST_EMPTY;
            m_data_d = m_data_q;
        end
    end

`endif

    // State and main-entry registers; reset clears the outputs to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
        end
    end

    // Saturating count of cycles in which EXE sees no valid bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] pc2;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] ext;
        logic [RW-1:0] rd;
    } bundle_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] pc_in, pc_plus2_in, op1_in, op2_in, extend_in;
    logic [RW-1:0] rd_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] pc_out, pc_plus2_out, op1_out, op2_out, extend_out;
    logic [RW-1:0] rd_out;
    logic [CW-1:0] bubble_cnt;

    pipe_stage_reg #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .pc_plus2_in  (pc_plus2_in),
        .op1_in       (op1_in),
        .op2_in       (op2_in),
        .extend_in    (extend_in),
        .rd_in        (rd_in),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc_out       (pc_out),
        .pc_plus2_out (pc_plus2_out),
        .op1_out      (op1_out),
        .op2_out      (op2_out),
        .extend_out   (extend_out),
        .rd_out       (rd_out),
        .bubble_cnt   (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of capacity 2 (skid) or 1 whose head drives the outputs
    bundle_t q[$];
    int      cnt_m;
    bit      rst_prev;
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bundle_t rand_b();
        bundle_t b;
        b.pc  = DW'($urandom);
        b.pc2 = DW'($urandom);
        b.op1 = DW'($urandom);
        b.op2 = DW'($urandom);
        b.ext = DW'($urandom);
        b.rd  = RW'($urandom);
        return b;
    endfunction

    function automatic bundle_t mk_b(input int pc, input int pc2, input int op1,
                                     input int op2, input int ext, input int rd);
        bundle_t b;
        b.pc  = DW'(pc);
        b.pc2 = DW'(pc2);
        b.op1 = DW'(op1);
        b.op2 = DW'(op2);
        b.ext = DW'(ext);
        b.rd  = RW'(rd);
        return b;
    endfunction

    // One clock cycle: drive, check DUT against model, then advance the model across the edge
    task automatic step(input bit rst, input bit iv, input bundle_t b, input bit ordy, input bit fl);
        bit      exp_rdy;
        bit      acc;
        bit      con;
        bundle_t seen;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        {pc_in, pc_plus2_in, op1_in, op2_in, extend_in, rd_in} = b;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
        seen    = {pc_out, pc_plus2_out, op1_out, op2_out, extend_out, rd_out};
        check_eq("out_valid", out_valid, q.size() != 0);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("bubble_cnt", bubble_cnt, cnt_m);
        if (q.size() != 0) check_eq("bundle", seen, q[0]);
        if (rst_prev) check_eq("reset_data", seen, 0);
        @(posedge clk);
        acc = iv && exp_rdy;
        con = (q.size() != 0) && ordy;
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (q.size() == 0 && cnt_m < CNT_MAX) cnt_m++;
            if (fl) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
        end
        rst_prev = rst;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_b(), ordy, 1'b0);
    endtask

    initial begin
        bundle_t a;
        bundle_t bb;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        {pc_in, pc_plus2_in, op1_in, op2_in, extend_in, rd_in} = '0;
        repeat (2) @(posedge clk);
        q.delete();
        cnt_m    = 0;
        rst_prev = 1'b1;

        // Release from reset, bubble counter 1,2,3 while idle
        idle(4, 1'b0);

        // Single bundle with same-cycle ready downstream
        step(1'b0, 1'b1, mk_b(1, 3, 101, 201, 301, 11), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Skid build with downstream stalled, then drain
        a  = mk_b(4, 6, 7, 8, 9, 2);
        bb = mk_b(6, 8, 17, 18, 19, 3);
        step(1'b0, 1'b1, a, 1'b0, 1'b0);
        step(1'b0, 1'b1, bb, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Flush while holding two bundles, with a new bundle offered
        step(1'b0, 1'b1, a, 1'b0, 1'b0);
        step(1'b0, 1'b1, bb, 1'b0, 1'b0);
        step(1'b0, 1'b1, rand_b(), 1'b0, 1'b1);
        idle(3, 1'b1);

        // Bubble counter saturation after reset
        step(1'b1, 1'b0, rand_b(), 1'b0, 1'b0);
        idle(20, 1'b0);

        // Mid-operation reset while holding a bundle
        step(1'b0, 1'b1, a, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, bb, 1'b1, 1'b0);
        step(1'b0, 1'b1, mk_b(1, 3, 101, 201, 301, 11), 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 60),
                 rand_b(),
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 3));
        end
        idle(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
